// File: rtl/bpu_pkg.sv
// Shared branch-predictor definitions: FSM states, update record and the
// weakly-taken counter encoding used when the PHT is initialised.
package bpu_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pht_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } upd_info_t;

    // Weakly taken: MSB set, all other counter bits clear.
    function automatic logic [31:0] weakly_taken(input int unsigned ctr_width);
        return 32'd1 << (ctr_width - 32'd1);
    endfunction

endpackage

// File: rtl/bpu_update_fifo.sv
// Update queue: two writes and one read per cycle, with an occupancy count.
// Write port 0 always lands ahead of write port 1 when both fire together.
module bpu_update_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr0_en,
    input  logic [WIDTH-1:0]         wr0_data,
    input  logic                     wr1_en,
    input  logic [WIDTH-1:0]         wr1_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wr1_slot;

    assign wr1_slot = wr0_en ? (wptr + PW'(1)) : wptr;
    assign rd_data  = mem[rptr];

    // Pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(wr0_en) + PW'(wr1_en);
            rptr  <= rptr + PW'(rd_en);
            count <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            mem[wptr] <= wr0_data;
        end
        if (wr1_en) begin
            mem[wr1_slot] <= wr1_data;
        end
    end

endmodule

// File: rtl/pht_update_ctrl.sv
// PHT update controller: sweeps the table to weakly-taken after reset, then
// queues commit updates and applies saturating counter writes, one per cycle.
module pht_update_ctrl
    import bpu_pkg::*;
#(
    parameter int TABLE_DEPTH_EXP2 = 10,
    parameter int CTR_WIDTH        = 2,
    parameter int PC_WIDTH         = 32,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        upd0_valid,
    input  logic [PC_WIDTH:0]           upd0_info,
    output logic                        upd0_ready,
    input  logic                        upd1_valid,
    input  logic [PC_WIDTH:0]           upd1_info,
    output logic                        upd1_ready,
    output logic [TABLE_DEPTH_EXP2-1:0] pht_raddr,
    input  logic [CTR_WIDTH-1:0]        pht_rdata,
    output logic                        pht_we,
    output logic [TABLE_DEPTH_EXP2-1:0] pht_waddr,
    output logic [CTR_WIDTH-1:0]        pht_wdata,
    output logic                        init_busy
);
    localparam int IW = TABLE_DEPTH_EXP2;
    localparam int EW = IW + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CTR_WIDTH-1:0] CTR_WT   = CTR_WIDTH'(weakly_taken(CTR_WIDTH));
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
    localparam logic [IW-1:0]        LAST_IDX = {IW{1'b1}};

    pht_state_e           state;
    logic [IW-1:0]        sweep_idx;
    logic [CW-1:0]        occupancy;
    logic [CW-1:0]        free_slots;
    logic [EW-1:0]        head;
    logic                 upd0_fire;
    logic                 upd1_fire;
    logic                 pop;
    logic [CTR_WIDTH-1:0] cur_ctr;
    logic                 unused_info_bits;

    function automatic logic [CTR_WIDTH-1:0] sat_update(input logic [CTR_WIDTH-1:0] ctr,
                                                         input logic taken);
        if (taken) begin
            return (ctr == CTR_MAX) ? ctr : ctr + CTR_WIDTH'(1);
        end else begin
            return (ctr == {CTR_WIDTH{1'b0}}) ? ctr : ctr - CTR_WIDTH'(1);
        end
    endfunction

    // Readies look only at registered occupancy, so a pop this cycle never frees a slot early.
    always_comb begin
        free_slots = CW'(FIFO_DEPTH) - occupancy;
        upd0_ready = 1'b0;
        upd1_ready = 1'b0;
        if (!init_busy) begin
            upd0_ready = (free_slots >= CW'(1));
            upd1_ready = (free_slots >= CW'(2)) || ((free_slots == CW'(1)) && !upd0_valid);
        end else begin
            upd0_ready = 1'b0;
            upd1_ready = 1'b0;
        end
    end

    assign upd0_fire = upd0_valid && upd0_ready;
    assign upd1_fire = upd1_valid && upd1_ready;
    assign pop       = (state == ST_RUN) && (occupancy != CW'(0));
    assign pht_raddr = head[EW-1:1];
    // The stage-2 write lands on the same edge we read, so bypass the stale table value.
    assign cur_ctr   = (pht_we && (pht_waddr == pht_raddr)) ? pht_wdata : pht_rdata;

    assign unused_info_bits = ^{upd0_info[PC_WIDTH:IW+3], upd0_info[2:1],
                                upd1_info[PC_WIDTH:IW+3], upd1_info[2:1]};

    bpu_update_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (upd0_fire),
        .wr0_data ({upd0_info[IW+2:3], upd0_info[0]}),
        .wr1_en   (upd1_fire),
        .wr1_data ({upd1_info[IW+2:3], upd1_info[0]}),
        .rd_en    (pop),
        .rd_data  (head),
        .count    (occupancy)
    );

    // Sweep/run FSM; the write port registers double as the stage-2 pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
            init_busy <= 1'b1;
            pht_we    <= 1'b0;
            pht_waddr <= '0;
            pht_wdata <= '0;
        end else begin
            init_busy <= (state == ST_INIT);
            case (state)
                ST_INIT: begin
                    pht_we    <= 1'b1;
                    pht_waddr <= sweep_idx;
                    pht_wdata <= CTR_WT;
                    sweep_idx <= sweep_idx + IW'(1);
                    if (sweep_idx == LAST_IDX) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    pht_we <= pop;
                    if (pop) begin
                        pht_waddr <= pht_raddr;
                        pht_wdata <= sat_update(cur_ctr, head[0]);
                    end
                end
                default: begin
                    state  <= ST_INIT;
                    pht_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Randomised scoreboard bench for pht_update_ctrl against a table-level model
// of counter updates, queue ordering and ready/latency timing.
module tb_pht_update_ctrl;
    localparam int TD   = 10;
    localparam int NENT = 1 << TD;
    localparam int QD   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd0_valid, upd1_valid;
    logic [32:0] upd0_info, upd1_info;
    logic        upd0_ready, upd1_ready;
    logic [9:0]  pht_raddr, pht_waddr;
    logic [1:0]  pht_rdata, pht_wdata;
    logic        pht_we, init_busy;

    typedef struct {
        int idx;
        int val;
        int cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [1:0] pht_mem [NENT];
    int         ref_tbl [NENT];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         acc_cnt = 0;
    int         wr_seen = 0;
    int         occ, base;
    bit         f0;
    bit         run_phase = 1'b0;

    pht_update_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .upd0_valid (upd0_valid),
        .upd0_info  (upd0_info),
        .upd0_ready (upd0_ready),
        .upd1_valid (upd1_valid),
        .upd1_info  (upd1_info),
        .upd1_ready (upd1_ready),
        .pht_raddr  (pht_raddr),
        .pht_rdata  (pht_rdata),
        .pht_we     (pht_we),
        .pht_waddr  (pht_waddr),
        .pht_wdata  (pht_wdata),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment PHT storage: combinational read, write on the clock edge.
    assign pht_rdata = pht_mem[pht_raddr];
    always @(posedge clk) if (pht_we === 1'b1) pht_mem[pht_waddr] <= pht_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int c, input bit t);
        if (t) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    task automatic push_exp(input logic [32:0] info, input int when);
        int idx;
        idx = int'(info[12:3]);
        ref_tbl[idx] = sat(ref_tbl[idx], info[0]);
        sb.push_back('{idx, ref_tbl[idx], when});
    endtask

    // Stimulus side: checks readies against modelled occupancy and queues expected writes.
    always @(negedge clk) begin
        if (run_phase) begin
            if (pht_we === 1'b1) wr_seen++;
            occ = acc_cnt - wr_seen;
            check("upd0_ready", {31'd0, upd0_ready}, {31'd0, (QD - occ) >= 1});
            check("upd1_ready", {31'd0, upd1_ready},
                  {31'd0, ((QD - occ) >= 2) || (((QD - occ) == 1) && !upd0_valid)});
            base = cyc + 2 + ((occ > 0) ? occ - 1 : 0);
            f0 = (upd0_valid === 1'b1) && (upd0_ready === 1'b1);
            if (f0) begin
                push_exp(upd0_info, base);
                acc_cnt++;
            end
            if ((upd1_valid === 1'b1) && (upd1_ready === 1'b1)) begin
                push_exp(upd1_info, base + (f0 ? 1 : 0));
                acc_cnt++;
            end
        end
    end

    // Monitor: every write in RUN must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (run_phase && (pht_we === 1'b1)) begin
            if (sb.size() == 0) begin
                check("spurious_we", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("waddr", {22'd0, pht_waddr}, e.idx);
                check("wdata", {30'd0, pht_wdata}, e.val);
                check("we_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input bit v0, input logic [31:0] pc0, input bit t0,
                         input bit v1, input logic [31:0] pc1, input bit t1);
        upd0_valid = v0; upd0_info = {pc0, t0};
        upd1_valid = v1; upd1_info = {pc1, t1};
        @(posedge clk); #1;
        upd0_valid = 1'b0;
        upd1_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        upd0_valid = 1'b0;
        upd1_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_init_busy", {31'd0, init_busy}, 32'd1);
        check("rst_ready0", {31'd0, upd0_ready}, 32'd0);
        check("rst_ready1", {31'd0, upd1_ready}, 32'd0);
        check("rst_we", {31'd0, pht_we}, 32'd0);
        check("rst_waddr", {22'd0, pht_waddr}, 32'd0);
        check("rst_wdata", {30'd0, pht_wdata}, 32'd0);
    endtask

    // Expects one weakly-taken write per cycle over the whole table, then RUN.
    task automatic check_init_sweep();
        int waited = 0;
        upd0_valid = 1'b1; upd0_info = {32'h0000_0010, 1'b1};
        upd1_valid = 1'b1; upd1_info = {32'h0000_0014, 1'b1};
        @(negedge clk);
        while ((pht_we !== 1'b1) && (waited < 8)) begin
            waited++;
            @(negedge clk);
        end
        check("init_start_we", {31'd0, pht_we}, 32'd1);
        if (pht_we === 1'b1) begin
            for (int i = 0; i < NENT; i++) begin
                check("init_we", {31'd0, pht_we}, 32'd1);
                check("init_waddr", {22'd0, pht_waddr}, i);
                check("init_wdata", {30'd0, pht_wdata}, 32'd2);
                check("init_busy_hi", {31'd0, init_busy}, 32'd1);
                check("init_readies", {30'd0, upd0_ready, upd1_ready}, 32'd0);
                if (i < NENT - 1) @(negedge clk);
            end
        end
        upd0_valid = 1'b0;
        upd1_valid = 1'b0;
        @(negedge clk);
        check("init_busy_fall", {31'd0, init_busy}, 32'd0);
        check("post_init_we", {31'd0, pht_we}, 32'd0);
        for (int i = 0; i < NENT; i++) ref_tbl[i] = 2;
        acc_cnt = 0;
        wr_seen = 0;
        run_phase = 1'b1;
    endtask

    task automatic random_burst(input int n);
        logic [31:0] pc0, pc1;
        for (int k = 0; k < n; k++) begin
            pc0 = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            pc1 = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), pc0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), pc1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1'b1;
        upd0_valid = 1'b1; upd0_info = '0;
        upd1_valid = 1'b1; upd1_info = '0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        rst = 1'b0;
        check_init_sweep();

        // Single taken update on a weakly-taken counter, then saturation.
        idle(1);
        drive(1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(4);
        check("req035_first", {30'd0, pht_mem[4]}, 32'd3);
        drive(1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(4);
        check("req035_saturate", {30'd0, pht_mem[4]}, 32'd3);

        // Same-cycle dual not-taken to one index exercises forwarding.
        drive(1'b1, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0020, 1'b0);
        idle(5);
        check("req036_final", {30'd0, pht_mem[8]}, 32'd0);

        // Back-to-back dual traffic drives the queue to one free slot.
        drive(1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0104, 1'b0);
        drive(1'b1, 32'h0000_0108, 1'b1, 1'b1, 32'h0000_010C, 1'b0);
        drive(1'b1, 32'h0000_0110, 1'b1, 1'b1, 32'h0000_0114, 1'b0);
        drive(1'b1, 32'h0000_0118, 1'b1, 1'b1, 32'h0000_011C, 1'b0);
        idle(8);

        // Floor at zero, then climb back from zero.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h0000_0030, 1'b0, 1'b0, 32'h0, 1'b0);
            idle(3);
        end
        check("req038_floor", {30'd0, pht_mem[12]}, 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0030, 1'b1);
        idle(4);
        check("req038_rise", {30'd0, pht_mem[12]}, 32'd1);

        random_burst(1500);
        idle(10);
        check("drain_empty", sb.size(), 32'd0);

        // Reset with three queued entries and one in flight.
        drive(1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0044, 1'b1);
        drive(1'b1, 32'h0000_0048, 1'b1, 1'b1, 32'h0000_004C, 1'b1);
        run_phase = 1'b0;
        rst = 1'b1;
        sb.delete();
        upd0_valid = 1'b1;
        upd1_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        rst = 1'b0;
        check_init_sweep();

        random_burst(200);
        idle(10);
        check("drain_empty_2", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
